// File: rtl/cpu_pio_gen.sv
// Avalon-MM parallel I/O slave: output register with atomic set/clear, synchronised input,
// optional edge capture with maskable level irq (enabled by defining CPU_PIO_EDGE_IRQ_EN).
module cpu_pio_gen #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  typedef enum logic [2:0] {
    A_DATA     = 3'd0,
    A_OUTDATA  = 3'd1,
    A_IRQMASK  = 3'd2,
    A_EDGECAP  = 3'd3,
    A_OUTSET   = 3'd4,
    A_OUTCLEAR = 3'd5
  } reg_addr_e;

  localparam logic [DATA_WIDTH-1:0] RST_OUT = RESET_VALUE[DATA_WIDTH-1:0];

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] s1, s2;
  logic [31:0]           rd_mux;
  logic                  unused_ok;

  assign wr        = chipselect && !write_n;
  assign wd        = writedata[DATA_WIDTH-1:0];
  assign unused_ok = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_port <= RST_OUT;
    end else if (wr) begin
      case (address)
        A_DATA:     out_port <= wd;
        A_OUTSET:   out_port <= out_port | wd;
        A_OUTCLEAR: out_port <= out_port & ~wd;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

`ifdef CPU_PIO_EDGE_IRQ_EN
  logic [DATA_WIDTH-1:0] s3, mask, cap;
  logic [DATA_WIDTH-1:0] edge_raw, edge_det, clr, cap_next, mask_next;
  logic [1:0]            warm;

  // Next-state values are shared by the registers and the irq term so irq tracks cap with no lag.
  always_comb begin
    if (EDGE_TYPE == 0)      edge_raw = s2 & ~s3;
    else if (EDGE_TYPE == 1) edge_raw = ~s2 & s3;
    else                     edge_raw = s2 ^ s3;
    edge_det  = (warm == 2'd3) ? edge_raw : '0;
    clr       = (wr && address == A_EDGECAP) ? wd : '0;
    mask_next = (wr && address == A_IRQMASK) ? wd : mask;
    cap_next  = (cap & ~clr) | edge_det;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s3   <= '0;
      warm <= '0;
      mask <= '0;
      cap  <= '0;
      irq  <= 1'b0;
    end else begin
      s3   <= s2;
      if (warm != 2'd3) warm <= warm + 2'd1;
      mask <= mask_next;
      cap  <= cap_next;
      irq  <= |(cap_next & mask_next);
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      A_DATA:    rd_mux[DATA_WIDTH-1:0] = s2;
      A_OUTDATA: rd_mux[DATA_WIDTH-1:0] = out_port;
`ifdef CPU_PIO_EDGE_IRQ_EN
      A_IRQMASK: rd_mux[DATA_WIDTH-1:0] = mask;
      A_EDGECAP: rd_mux[DATA_WIDTH-1:0] = cap;
`endif
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

endmodule

// File: tb/tb_cpu_pio_gen.sv
// Self-checking bench for cpu_pio_gen: rising-edge (dut0) and any-edge (dut2) instances share one bus.
module tb_cpu_pio_gen;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = '0;
  logic [31:0] rd0, rd2;
  logic [7:0]  out0, out2;
  logic        irq0, irq2;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v, exp_w;

  always #5 clk = ~clk;

  cpu_pio_gen #(.DATA_WIDTH(8), .RESET_VALUE(32'hA5), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd0), .in_port(in_port), .out_port(out0), .irq(irq0));

  cpu_pio_gen #(.DATA_WIDTH(8), .RESET_VALUE(32'hA5), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd2), .in_port(in_port), .out_port(out2), .irq(irq2));

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    chipselect = 1'b0;
  endtask

  task automatic test_reset;
    in_port = 8'hFF;
    reset = 1'b1;
    address = 3'd1;
    tick(3);
    tests_run++;
    if (out0 !== 8'hA5 || out2 !== 8'hA5) begin
      tests_failed++; $display("FAIL reset_out: got %h/%h expected a5", out0, out2);
    end
    tests_run++;
    if (rd0 !== 32'h0 || irq0 !== 1'b0) begin
      tests_failed++; $display("FAIL reset_rd_irq: got rd=%h irq=%b expected 0/0", rd0, irq0);
    end
    reset = 1'b0;
    address = 3'd3;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'h0);
      tick();
      exp_v = exp_q.pop_front();
      tests_run++;
      if (rd0 !== exp_v || rd2 !== exp_v || irq0 !== 1'b0 || irq2 !== 1'b0) begin
        tests_failed++;
        $display("FAIL warmup_no_cap[%0d]: got %h/%h irq %b/%b expected %h", i, rd0, rd2, irq0, irq2, exp_v);
      end
    end
    exp_q.push_back(32'h000000A5);
    bus_rd(3'd1);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (rd0 !== exp_v) begin
      tests_failed++; $display("FAIL reset_rd_outdata: got %h expected %h", rd0, exp_v);
    end
  endtask

  task automatic test_out_ops;
    logic [2:0]  addrs[6];
    logic [31:0] datas[6];
    logic [7:0]  exps[6];
    addrs = '{3'd0, 3'd4, 3'd5, 3'd1, 3'd6, 3'd7};
    datas = '{32'h0F, 32'hC0, 32'h03, 32'hFF, 32'hFF, 32'h00};
    exps  = '{8'h0F, 8'hCF, 8'hCC, 8'hCC, 8'hCC, 8'hCC};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({24'h0, exps[i]});
      bus_wr(addrs[i], datas[i]);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (out0 !== exp_v[7:0] || out2 !== exp_v[7:0]) begin
        tests_failed++; $display("FAIL out_write[%0d]: got %h expected %h", i, out0, exp_v[7:0]);
      end
    end
    for (int a = 4; a < 8; a++) begin
      exp_q.push_back(32'h0);
      bus_rd(3'(a));
      exp_v = exp_q.pop_front();
      tests_run++;
      if (rd0 !== exp_v) begin
        tests_failed++; $display("FAIL rd_zero_addr%0d: got %h expected %h", a, rd0, exp_v);
      end
    end
    bus_wr(3'd0, 32'hFFFF_FF3C);
    exp_q.push_back(32'h0000003C);
    bus_rd(3'd1);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (rd0 !== exp_v) begin
      tests_failed++; $display("FAIL rd_after_wr: got %h expected %h", rd0, exp_v);
    end
  endtask

  task automatic test_data_in;
    exp_q.push_back(32'hFF);
    bus_rd(3'd0);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (rd0 !== exp_v) begin
      tests_failed++; $display("FAIL data_in_ff: got %h expected %h", rd0, exp_v);
    end
    in_port = 8'h5A;
    address = 3'd0;
    exp_q.push_back(32'hFF);
    exp_q.push_back(32'h5A);
    tick(2);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (rd0 !== exp_v) begin
      tests_failed++; $display("FAIL data_in_early: got %h expected %h", rd0, exp_v);
    end
    tick();
    exp_v = exp_q.pop_front();
    tests_run++;
    if (rd0 !== exp_v) begin
      tests_failed++; $display("FAIL data_in_latency: got %h expected %h", rd0, exp_v);
    end
    in_port = 8'h00;
    tick(3);
  endtask

`ifdef CPU_PIO_EDGE_IRQ_EN
  task automatic test_edge_irq;
    bus_wr(3'd3, 32'hFF);
    bus_wr(3'd2, 32'h01);
    in_port = 8'h01;
    tick(2);
    tests_run++;
    if (irq0 !== 1'b0) begin
      tests_failed++; $display("FAIL irq_early: got %b expected 0", irq0);
    end
    tick();
    tests_run++;
    if (irq0 !== 1'b1) begin
      tests_failed++; $display("FAIL irq_rise: got %b expected 1", irq0);
    end
    exp_q.push_back(32'h01);
    bus_rd(3'd3);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (rd0 !== exp_v) begin
      tests_failed++; $display("FAIL cap_read: got %h expected %h", rd0, exp_v);
    end
    bus_wr(3'd3, 32'h01);
    tests_run++;
    if (irq0 !== 1'b0) begin
      tests_failed++; $display("FAIL irq_clear: got %b expected 0", irq0);
    end
  endtask

  task automatic test_clear_collision;
    in_port = 8'h00; tick(3);
    in_port = 8'h01; tick(3);
    in_port = 8'h00; tick(3);
    tests_run++;
    if (irq0 !== 1'b1) begin
      tests_failed++; $display("FAIL irq_hold: got %b expected 1", irq0);
    end
    in_port = 8'h01;
    tick(2);
    bus_wr(3'd3, 32'h01);
    tick(2);
    tests_run++;
    if (irq0 !== 1'b1) begin
      tests_failed++; $display("FAIL collision_irq: got %b expected 1", irq0);
    end
    exp_q.push_back(32'h01);
    bus_rd(3'd3);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (rd0 !== exp_v) begin
      tests_failed++; $display("FAIL collision_cap: got %h expected %h", rd0, exp_v);
    end
    bus_wr(3'd3, 32'h01);
    tests_run++;
    if (irq0 !== 1'b0) begin
      tests_failed++; $display("FAIL collision_clear: got %b expected 0", irq0);
    end
  endtask

  task automatic test_any_edge;
    bus_wr(3'd3, 32'hFF);
    in_port = 8'h03; tick(3);
    exp_q.push_back(32'h02);
    exp_q.push_back(32'h02);
    bus_rd(3'd3);
    exp_v = exp_q.pop_front();
    exp_w = exp_q.pop_front();
    tests_run++;
    if (rd2 !== exp_v || rd0 !== exp_w || irq2 !== 1'b0) begin
      tests_failed++; $display("FAIL any_rise: got %h/%h irq=%b expected %h/%h irq=0", rd2, rd0, irq2, exp_v, exp_w);
    end
    bus_wr(3'd3, 32'h02);
    in_port = 8'h01; tick(3);
    exp_q.push_back(32'h02);
    exp_q.push_back(32'h00);
    bus_rd(3'd3);
    exp_v = exp_q.pop_front();
    exp_w = exp_q.pop_front();
    tests_run++;
    if (rd2 !== exp_v || rd0 !== exp_w || irq2 !== 1'b0) begin
      tests_failed++; $display("FAIL any_fall: got %h/%h irq=%b expected %h/%h irq=0", rd2, rd0, irq2, exp_v, exp_w);
    end
    bus_wr(3'd2, 32'h03);
    tests_run++;
    if (irq2 !== 1'b1 || irq0 !== 1'b0) begin
      tests_failed++; $display("FAIL any_mask_irq: got %b/%b expected 1/0", irq2, irq0);
    end
    exp_q.push_back(32'h03);
    bus_rd(3'd2);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (rd2 !== exp_v) begin
      tests_failed++; $display("FAIL mask_read: got %h expected %h", rd2, exp_v);
    end
  endtask
`else
  task automatic test_no_edge;
    bus_wr(3'd2, 32'hFF);
    bus_wr(3'd3, 32'hFF);
    in_port = 8'hFF; tick(4);
    in_port = 8'h00; tick(4);
    for (int a = 2; a < 4; a++) begin
      exp_q.push_back(32'h0);
      bus_rd(3'(a));
      exp_v = exp_q.pop_front();
      tests_run++;
      if (rd0 !== exp_v || rd2 !== exp_v || irq0 !== 1'b0 || irq2 !== 1'b0) begin
        tests_failed++;
        $display("FAIL no_edge_addr%0d: got %h/%h irq %b/%b expected %h", a, rd0, rd2, irq0, irq2, exp_v);
      end
    end
  endtask
`endif

  task automatic test_reset_override;
    reset = 1'b1;
    bus_wr(3'd0, 32'h33);
    tests_run++;
    if (out0 !== 8'hA5 || rd0 !== 32'h0 || irq0 !== 1'b0 || irq2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_override: got out=%h rd=%h irq=%b/%b expected a5/0/0/0", out0, rd0, irq0, irq2);
    end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_out_ops();
    test_data_in();
`ifdef CPU_PIO_EDGE_IRQ_EN
    test_edge_irq();
    test_clear_collision();
    test_any_edge();
`else
    test_no_edge();
`endif
    test_reset_override();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
